// File: rtl/ysyx_23060229_mem_arb.sv
// Shares one memory master port between instruction fetch and load/store.
// One transaction in flight; a watchdog retires hung accesses with an error.
module ysyx_23060229_mem_arb #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ifu_req,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_gnt,
    output logic          ifu_rvalid,
    output logic [DW-1:0] ifu_rdata,
    output logic          ifu_err,
    input  logic          lsu_req,
    input  logic          lsu_wen,
    input  logic [AW-1:0] lsu_addr,
    input  logic [DW-1:0] lsu_wdata,
    input  logic [7:0]    lsu_wmask,
    output logic          lsu_gnt,
    output logic          lsu_rvalid,
    output logic [DW-1:0] lsu_rdata,
    output logic          lsu_err,
    output logic          mem_req,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [7:0]    mem_wmask,
    input  logic          mem_ready,
    input  logic          mem_resp,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          owner;
    logic          last_owner;
    logic          wen_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [7:0]    wmask_q;
    logic [DW-1:0] rdata_q;
    logic          err_q;
    logic [CW-1:0] cnt;

    logic idle;
    logic busy;
    logic pick_lsu;
    logic ifu_win;
    logic lsu_win;
    logic fin;
    logic hit_to;

    // owner/last_owner encode 1 = LSU, 0 = IFU
    assign idle     = (state == IDLE) & rst;
    assign busy     = (state == ISSUE) | (state == WAIT);
    assign pick_lsu = lsu_req & (~ifu_req | ~last_owner);
    assign ifu_win  = idle & ifu_req & ~pick_lsu;
    assign lsu_win  = idle & pick_lsu;
    assign fin      = ((state == ISSUE) & mem_ready & mem_resp)
                    | ((state == WAIT) & mem_resp);
    assign hit_to   = busy & (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (ifu_win | lsu_win) state_nx = ISSUE;
            end
            ISSUE: begin
                if (fin | hit_to)      state_nx = DONE;
                else if (mem_ready)    state_nx = WAIT;
            end
            WAIT: begin
                if (fin | hit_to)      state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= 1'b0;
            last_owner <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            if (ifu_win | lsu_win) begin
                owner   <= lsu_win;
                wen_q   <= lsu_win & lsu_wen;
                addr_q  <= lsu_win ? lsu_addr : ifu_addr;
                wdata_q <= (lsu_win & lsu_wen) ? lsu_wdata : '0;
                wmask_q <= (lsu_win & lsu_wen) ? lsu_wmask : '0;
                cnt     <= '0;
            end else if (busy) begin
                cnt <= cnt + 1'b1;
            end
            // A completion in the timeout cycle still wins
            if (fin) begin
                rdata_q <= wen_q ? '0 : mem_rdata;
                err_q   <= 1'b0;
            end else if (hit_to) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end else if (state == DONE) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
            if (state == DONE) last_owner <= owner;
        end
    end

    always_comb begin
        ifu_gnt    = ifu_win;
        lsu_gnt    = lsu_win;
        mem_req    = (state == ISSUE);
        mem_wen    = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wmask  = '0;
        ifu_rvalid = 1'b0;
        ifu_rdata  = '0;
        ifu_err    = 1'b0;
        lsu_rvalid = 1'b0;
        lsu_rdata  = '0;
        lsu_err    = 1'b0;
        if (state == ISSUE) begin
            mem_wen   = wen_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_wmask = wmask_q;
        end
        if (state == DONE) begin
            if (owner) begin
                lsu_rvalid = 1'b1;
                lsu_rdata  = rdata_q;
                lsu_err    = err_q;
            end else begin
                ifu_rvalid = 1'b1;
                ifu_rdata  = rdata_q;
                ifu_err    = err_q;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060229_mem_arb.sv
// Bench for the IFU/LSU memory arbiter: scripted requests, a reactive
// memory model and a response scoreboard checked on every rvalid.
module tb_ysyx_23060229_mem_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req = 1'b0;
    logic [31:0] ifu_addr = '0;
    logic        ifu_gnt;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic        ifu_err;
    logic        lsu_req = 1'b0;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdata = '0;
    logic [7:0]  lsu_wmask = '0;
    logic        lsu_gnt;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic        mem_req;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_ready = 1'b0;
    logic        mem_resp = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;
    logic [33:0] sb[$];

    int rdy_dly = 0;
    int resp_dly = 0;
    int m_cnt = 0;
    int m_wait = 0;
    bit m_acc = 1'b0;
    logic [31:0] m_data = '0;

    ysyx_23060229_mem_arb #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_gnt(lsu_gnt),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ready(mem_ready), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_of(logic [31:0] a);
        return a ^ 32'h8000_0413;
    endfunction

    // memory: ready rdy_dly cycles into ISSUE (<0 never), resp resp_dly later
    always begin
        @(posedge clk);
        #2;
        mem_ready = 1'b0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        if (!rst) begin
            m_acc = 1'b0;
            m_cnt = 0;
        end else if (m_acc) begin
            m_wait++;
            if (m_wait >= resp_dly) begin
                mem_resp  = 1'b1;
                mem_rdata = m_data;
                m_acc     = 1'b0;
            end
        end else if (mem_req) begin
            if (rdy_dly >= 0 && m_cnt >= rdy_dly) begin
                mem_ready = 1'b1;
                m_cnt     = 0;
                m_wait    = 0;
                m_data    = mem_wen ? 32'hFFFF_FFFF : rd_of(mem_addr);
                if (resp_dly == 0) begin
                    mem_resp  = 1'b1;
                    mem_rdata = m_data;
                end else begin
                    m_acc = 1'b1;
                end
            end else begin
                m_cnt++;
            end
        end else begin
            m_cnt = 0;
        end
    end

    // scoreboard: {is_lsu, err, rdata}
    always @(negedge clk) begin
        logic [33:0] exp_r;
        logic [33:0] got_r;
        if (ifu_rvalid || lsu_rvalid) begin
            checks++;
            got_r = lsu_rvalid ? {1'b1, lsu_err, lsu_rdata}
                               : {1'b0, ifu_err, ifu_rdata};
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got=%h required=none", got_r);
            end else begin
                exp_r = sb.pop_front();
                if (got_r !== exp_r || (ifu_rvalid && lsu_rvalid)) begin
                    errors++;
                    $display("FAIL sb_rsp got=%h both=%b required=%h",
                             got_r, ifu_rvalid && lsu_rvalid, exp_r);
                end
            end
        end
        checks++;
        if ((!ifu_rvalid && (ifu_rdata !== 0 || ifu_err !== 0)) ||
            (!lsu_rvalid && (lsu_rdata !== 0 || lsu_err !== 0))) begin
            errors++;
            $display("FAIL idle_zero ifu=%h/%b lsu=%h/%b required=0",
                     ifu_rdata, ifu_err, lsu_rdata, lsu_err);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rvalid(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ifu_rvalid || lsu_rvalid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset;
        rst = 1'b0;
        ifu_req = 1'b0;
        lsu_req = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b0;
        ifu_req = 1'b1;
        lsu_req = 1'b1;
        lsu_addr = 32'h8000_0010;
        #1;
        checks++;
        if ({ifu_gnt, lsu_gnt, mem_req, ifu_rvalid, lsu_rvalid} !== 5'b0 ||
            mem_addr !== 0 || mem_wmask !== 0) begin
            errors++;
            $display("FAIL reset_out gnt=%b%b req=%b rv=%b%b addr=%h required=0",
                     ifu_gnt, lsu_gnt, mem_req, ifu_rvalid, lsu_rvalid, mem_addr);
        end
        tick();
        ifu_req = 1'b0;
        lsu_req = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if ({ifu_gnt, lsu_gnt, mem_req} !== 3'b0) begin
            errors++;
            $display("FAIL reset_idle gnt=%b%b req=%b required=000",
                     ifu_gnt, lsu_gnt, mem_req);
        end
    endtask

    task automatic test_arbitration;
        int n;
        logic [31:0] ia;
        logic [31:0] la;
        logic lw;
        do_reset();
        rdy_dly = 0;
        resp_dly = 1;
        for (int r = 0; r < 4; r++) begin
            ia = 32'h8000_0100 + 32'(r * 4);
            la = 32'h8000_2000 + 32'(r * 8);
            lw = (r % 2 == 0);
            ifu_req = 1'b1;
            ifu_addr = ia;
            lsu_req = 1'b1;
            lsu_wen = 1'b0;
            lsu_addr = la;
            #1;
            checks++;
            if (lsu_gnt !== lw || ifu_gnt !== !lw) begin
                errors++;
                $display("FAIL arb_gnt round=%0d got=%b%b required=%b%b",
                         r, ifu_gnt, lsu_gnt, !lw, lw);
            end
            sb.push_back(lw ? {1'b1, 1'b0, rd_of(la)} : {1'b0, 1'b0, rd_of(ia)});
            tick();
            checks++;
            if (ifu_gnt !== 1'b0 || lsu_gnt !== 1'b0) begin
                errors++;
                $display("FAIL arb_busy_gnt round=%0d got=%b%b required=00",
                         r, ifu_gnt, lsu_gnt);
            end
            ifu_req = 1'b0;
            lsu_req = 1'b0;
            wait_rvalid(n);
            checks++;
            if (n !== 2) begin
                errors++;
                $display("FAIL arb_latency round=%0d got=%0d required=2", r, n);
            end
            tick();
        end
    endtask

    task automatic test_ifu_fetch;
        int n;
        rdy_dly = 0;
        resp_dly = 2;
        ifu_req = 1'b1;
        ifu_addr = 32'h8000_0000;
        #1;
        checks++;
        if (ifu_gnt !== 1'b1 || lsu_gnt !== 1'b0) begin
            errors++;
            $display("FAIL fetch_gnt got=%b%b required=10", ifu_gnt, lsu_gnt);
        end
        sb.push_back({1'b0, 1'b0, 32'h0000_0413});
        tick();
        ifu_req = 1'b0;
        ifu_addr = 32'hDEAD_0000;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0000 ||
            mem_wen !== 1'b0 || mem_wmask !== 8'h00) begin
            errors++;
            $display("FAIL fetch_issue req=%b addr=%h wen=%b mask=%h required=1/80000000/0/00",
                     mem_req, mem_addr, mem_wen, mem_wmask);
        end
        wait_rvalid(n);
        checks++;
        if (n !== 3 || ifu_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL fetch_latency got=%0d rv=%b required=3/1", n, ifu_rvalid);
        end
        tick();
        checks++;
        if (ifu_rvalid !== 1'b0 || ifu_rdata !== 0) begin
            errors++;
            $display("FAIL fetch_pulse rv=%b data=%h required=0/0", ifu_rvalid, ifu_rdata);
        end
    endtask

    task automatic test_store;
        int n;
        rdy_dly = 1;
        resp_dly = 1;
        lsu_req = 1'b1;
        lsu_wen = 1'b1;
        lsu_addr = 32'h8000_1000;
        lsu_wdata = 32'hDEAD_BEEF;
        lsu_wmask = 8'h0F;
        #1;
        checks++;
        if (lsu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL store_gnt got=%b required=1", lsu_gnt);
        end
        sb.push_back({1'b1, 1'b0, 32'h0});
        tick();
        lsu_req = 1'b0;
        lsu_wen = 1'b0;
        lsu_addr = '0;
        lsu_wdata = '0;
        lsu_wmask = '0;
        checks++;
        if (mem_req !== 1'b1 || mem_wen !== 1'b1 || mem_wmask !== 8'h0F ||
            mem_addr !== 32'h8000_1000 || mem_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL store_issue req=%b wen=%b mask=%h addr=%h wdata=%h required=1/1/0f/80001000/deadbeef",
                     mem_req, mem_wen, mem_wmask, mem_addr, mem_wdata);
        end
        wait_rvalid(n);
        checks++;
        if (n !== 3 || lsu_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL store_latency got=%0d rv=%b required=3/1", n, lsu_rvalid);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        int n;
        rdy_dly = 0;
        resp_dly = 0;
        for (int k = 0; k < 2; k++) begin
            ifu_req = (k == 1);
            ifu_addr = 32'h8000_3100;
            lsu_req = (k == 0);
            lsu_wen = 1'b0;
            lsu_addr = 32'h8000_3000;
            #1;
            checks++;
            if ((k == 0 && lsu_gnt !== 1'b1) || (k == 1 && ifu_gnt !== 1'b1)) begin
                errors++;
                $display("FAIL fast_gnt k=%0d got=%b%b", k, ifu_gnt, lsu_gnt);
            end
            sb.push_back(k == 0 ? {1'b1, 1'b0, rd_of(32'h8000_3000)}
                                : {1'b0, 1'b0, rd_of(32'h8000_3100)});
            tick();
            ifu_req = 1'b0;
            lsu_req = 1'b0;
            wait_rvalid(n);
            checks++;
            if (n !== 1) begin
                errors++;
                $display("FAIL fast_latency k=%0d got=%0d required=1", k, n);
            end
            tick();
        end
    endtask

    task automatic test_timeout;
        int n;
        rdy_dly = -1;
        lsu_req = 1'b1;
        lsu_wen = 1'b0;
        lsu_addr = 32'h8000_4000;
        #1;
        checks++;
        if (lsu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL to_gnt got=%b required=1", lsu_gnt);
        end
        sb.push_back({1'b1, 1'b1, 32'h0});
        tick();
        lsu_req = 1'b0;
        wait_rvalid(n);
        checks++;
        if (n !== 8 || lsu_err !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL to_done got=%0d err=%b req=%b required=8/1/0",
                     n, lsu_err, mem_req);
        end
        tick();
        rdy_dly = 0;
        resp_dly = 0;
        ifu_req = 1'b1;
        ifu_addr = 32'h8000_4100;
        #1;
        checks++;
        if (ifu_gnt !== 1'b1 || lsu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL to_idle gnt=%b rv=%b required=1/0", ifu_gnt, lsu_rvalid);
        end
        sb.push_back({1'b0, 1'b0, rd_of(32'h8000_4100)});
        tick();
        ifu_req = 1'b0;
        wait_rvalid(n);
        tick();
    endtask

    task automatic test_reset_mid;
        int n;
        int extra;
        rdy_dly = 0;
        resp_dly = 5;
        ifu_req = 1'b1;
        ifu_addr = 32'h8000_5000;
        #1;
        checks++;
        if (ifu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rmid_gnt got=%b required=1", ifu_gnt);
        end
        tick();
        ifu_req = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || ifu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_wait req=%b rv=%b required=0/0", mem_req, ifu_rvalid);
        end
        tick();
        rst = 1'b1;
        rdy_dly = -1;
        tick();
        ifu_req = 1'b1;
        #1;
        tick();
        ifu_req = 1'b0;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rmid_issue req=%b required=1", mem_req);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async req=%b required=0", mem_req);
        end
        tick();
        rst = 1'b1;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ifu_rvalid || lsu_rvalid) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL rmid_norv got=%0d required=0", extra);
        end
        rdy_dly = 0;
        resp_dly = 1;
        ifu_req = 1'b1;
        ifu_addr = 32'h8000_5004;
        #1;
        checks++;
        if (ifu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rmid_regnt got=%b required=1", ifu_gnt);
        end
        sb.push_back({1'b0, 1'b0, rd_of(32'h8000_5004)});
        tick();
        ifu_req = 1'b0;
        wait_rvalid(n);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL rmid_latency got=%0d required=2", n);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_arbitration();
        test_ifu_fetch();
        test_store();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        repeat (2) tick();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL sb_leftover got=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
